// File: rtl/keypad_scanner.sv
// keypad_scanner: debounced 4x4 matrix keypad scanner.
// Drives one column low at a time; outputs key index, hold level and press strobe.
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [3:0] posicion,
  output logic       opr,
  output logic       pulse
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEB,
    S_HELD
  } state_t;

  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [DW-1:0] r_div;
  logic [1:0]    r_ci;
  logic [3:0]    r_col;
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [BW-1:0] r_cnt;
  logic [3:0]    r_pos;
  logic          r_opr;
  logic          r_pulse;

  logic          w_tick;
  logic          w_hit;
  logic [1:0]    w_row;
  logic [3:0]    w_key;
  logic          w_up;

  assign w_tick = (r_div == DIV_LAST);
  assign w_hit  = ~&r_s2;
  assign w_key  = {w_row, r_ci};
  assign w_up   = r_s2[r_cand[3:2]];

  // lowest active-low row wins when several are pressed
  always_comb begin
    w_row = 2'd0;
    priority case (1'b1)
      !r_s2[0]: w_row = 2'd0;
      !r_s2[1]: w_row = 2'd1;
      !r_s2[2]: w_row = 2'd2;
      !r_s2[3]: w_row = 2'd3;
      default:  w_row = 2'd0;
    endcase
  end

  // two-flop synchronizer; idle rows read high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 4'hF;
      r_s2 <= 4'hF;
    end else begin
      r_s1 <= fila;
      r_s2 <= r_s1;
    end
  end

  // column dwell counter; terminal count is the sample instant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // scan / debounce / held state machine with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_SCAN;
      r_ci    <= 2'd0;
      r_col   <= 4'b1110;
      r_cand  <= 4'd0;
      r_cnt   <= '0;
      r_pos   <= 4'd0;
      r_opr   <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (w_tick) begin
        case (r_state)
          S_SCAN: begin
            if (w_hit) begin
              r_cand <= w_key;
              if (DEBOUNCE == 1) begin
                r_state <= S_HELD;
                r_pos   <= w_key;
                r_opr   <= 1'b1;
                r_pulse <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_state <= S_DEB;
                r_cnt   <= BW'(1);
              end
            end else begin
              r_ci  <= r_ci + 2'd1;
              r_col <= {r_col[2:0], r_col[3]};
            end
          end
          S_DEB: begin
            if (w_hit && (w_key == r_cand)) begin
              if (r_cnt == DB_LAST) begin
                r_state <= S_HELD;
                r_pos   <= r_cand;
                r_opr   <= 1'b1;
                r_pulse <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + BW'(1);
              end
            end else begin
              r_state <= S_SCAN;
              r_cnt   <= '0;
              r_ci    <= r_ci + 2'd1;
              r_col   <= {r_col[2:0], r_col[3]};
            end
          end
          S_HELD: begin
            if (!w_up) begin
              r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
              r_state <= S_SCAN;
              r_opr   <= 1'b0;
              r_cnt   <= '0;
              r_ci    <= r_ci + 2'd1;
              r_col   <= {r_col[2:0], r_col[3]};
            end else begin
              r_cnt <= r_cnt + BW'(1);
            end
          end
          default: begin
            r_state <= S_SCAN;
          end
        endcase
      end
    end
  end

  assign col      = r_col;
  assign posicion = r_pos;
  assign opr      = r_opr;
  assign pulse    = r_pulse;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model + scoreboard of expected accepted presses.
// Each accepted press must produce one pulse carrying the pressed key index.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  fila;
  logic [3:0]  col;
  logic [3:0]  posicion;
  logic        opr;
  logic        pulse;
  logic [15:0] keys = '0;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int m_exp;
  int k;

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fila(fila),
    .col(col),
    .posicion(posicion),
    .opr(opr),
    .pulse(pulse)
  );

  always #5 clk = ~clk;

  // physical keypad: a pressed key shorts its row to its driven-low column
  always_comb begin
    fila = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) fila[r] = 1'b0;
  end

  // monitor: every pulse must match the oldest expected press
  always @(negedge clk) begin
    if (rst && pulse) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse got pos=%0d want no pulse", posicion);
      end else begin
        m_exp = exp_q.pop_front();
        if (posicion != 4'(m_exp) || !opr) begin
          bad++;
          $display("FAIL pulse_pos got=%0d opr=%0b want=%0d opr=1",
                   posicion, opr, m_exp);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_col(input logic [3:0] c, input string nm);
    int i = 0;
    while (col !== c && i < 100) begin
      tick(1);
      i++;
    end
    chk(nm, int'(col), int'(c));
  endtask

  task automatic wait_opr(input logic v, input string nm);
    int i = 0;
    while (opr !== v && i < 200) begin
      tick(1);
      i++;
    end
    chk(nm, int'(opr), int'(v));
  endtask

  // 7-cycle presses span at most 2 samples; 5-cycle gaps hold a sample
  task automatic bounce(input int key);
    repeat (4) begin
      keys[key] = 1'b1;
      tick(7);
      keys[key] = 1'b0;
      tick(5);
    end
    tick(10);
    chk("bounce_opr", int'(opr), 0);
  endtask

  initial begin
    logic [3:0] ec;
    @(negedge clk);
    tick(3);
    rst = 1'b1;
    tick(10);
    rst = 1'b0;
    #1;
    chk("rst_col", int'(col), 4'b1110);
    chk("rst_opr", int'(opr), 0);
    chk("rst_pulse", int'(pulse), 0);
    chk("rst_pos", int'(posicion), 0);
    tick(2);
    rst = 1'b1;

    for (int j = 1; j <= 16; j++) begin
      tick(1);
      ec = ~(4'b0001 << ((j / 4) % 4));
      chk("idle_col", int'(col), int'(ec));
    end

    wait_col(4'b1101, "reach_col1");
    exp_q.push_back(9);
    keys[9] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      if (n == 11) chk("press_early", int'(opr), 0);
      if (n == 12) begin
        chk("press_opr", int'(opr), 1);
        chk("press_pos", int'(posicion), 9);
        chk("press_pulse", int'(pulse), 1);
      end
    end
    keys[9] = 1'b0;
    for (int m = 1; m <= 12; m++) begin
      tick(1);
      if (m == 1) chk("pulse_width", int'(pulse), 0);
      if (m == 11) begin
        chk("rel_early", int'(opr), 1);
        chk("held_col", int'(col), 4'b1101);
      end
      if (m == 12) begin
        chk("rel_opr", int'(opr), 0);
        chk("rel_col", int'(col), 4'b1011);
        chk("rel_pos", int'(posicion), 9);
      end
    end

    wait_col(4'b0111, "reach_col3");
    bounce(3);
    wait_col(4'b1110, "scan_resumes");

    exp_q.push_back(4);
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
    wait_opr(1'b1, "multi_opr");
    chk("multi_pos", int'(posicion), 4);
    keys[15] = 1'b1;
    tick(40);
    chk("ignore_pos", int'(posicion), 4);
    chk("ignore_opr", int'(opr), 1);
    chk("ignore_col", int'(col), 4'b1110);
    keys = '0;
    wait_opr(1'b0, "multi_rel");

    k = int'($urandom_range(0, 15));
    exp_q.push_back(k);
    keys[k] = 1'b1;
    wait_opr(1'b1, "prerst_opr");
    tick(3);
    rst = 1'b0;
    #1;
    chk("midrst_opr", int'(opr), 0);
    chk("midrst_col", int'(col), 4'b1110);
    chk("midrst_pulse", int'(pulse), 0);
    tick(2);
    rst = 1'b1;
    exp_q.push_back(k);
    wait_opr(1'b1, "postrst_opr");
    chk("postrst_pos", int'(posicion), k);
    keys = '0;
    wait_opr(1'b0, "postrst_rel");

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        bounce(int'($urandom_range(0, 15)));
      end else begin
        k = int'($urandom_range(0, 15));
        exp_q.push_back(k);
        keys[k] = 1'b1;
        wait_opr(1'b1, "rand_opr");
        tick(int'($urandom_range(0, 8)));
        keys[k] = 1'b0;
        wait_opr(1'b0, "rand_rel");
        chk("rand_pos", int'(posicion), k);
      end
      tick(int'($urandom_range(0, 9)));
    end

    tick(5);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
